// File: rtl/wash_sequencer.sv
// wash_sequencer: fetches, decodes and runs 32-bit wash instructions from the program ROM.
// Optional `pause` input (freezes RUN timing and actuators) is enabled by defining WASH_PAUSE_EN.
module wash_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_SIZE = 64,
  parameter int START_PC = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  tick,
`ifdef WASH_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fill_valve,
  output logic                  drain_valve,
  output logic                  motor_fwd,
  output logic                  motor_rev,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  loop_cnt
);
  typedef enum logic [1:0] {IDLE, DECODE, RUN, FAULT} state_t;
  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_WAIT = 8'h01;
  localparam logic [7:0] OP_FILL = 8'h02;
  localparam logic [7:0] OP_REL  = 8'h03;
  localparam logic [7:0] OP_FWD  = 8'h04;
  localparam logic [7:0] OP_REV  = 8'h05;
  localparam logic [7:0] OP_SET  = 8'h11;
  localparam logic [7:0] OP_DEC  = 8'h12;
  localparam logic [7:0] OP_JZ   = 8'h21;
  localparam logic [7:0] OP_JNZ  = 8'h22;
  localparam logic [ADDR_WIDTH:0] PC_END = (ADDR_WIDTH+1)'(ROM_SIZE);
  localparam logic [15:0] IMM_END = 16'(ROM_SIZE);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc_n;
  logic [ADDR_WIDTH:0] pc_inc;
  logic [CNT_WIDTH-1:0] lc_n;
  logic [15:0] imm, timer, timer_n;
  logic [7:0] op;
  logic [3:0] sel, sel_n, act_n;
  logic done_n, adv, jmp, paused, inc_bad, tgt_bad, unused;
  assign imm = instr[31:16];
  assign op = instr[7:0];
  assign unused = ^instr[15:8];
  assign pc_inc = {1'b0, pc} + (ADDR_WIDTH+1)'(1);
  assign inc_bad = pc_inc >= PC_END;
  // imm >= ROM_SIZE also covers nonzero bits above the address field
  assign tgt_bad = imm >= IMM_END;
`ifdef WASH_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    lc_n = loop_cnt;
    timer_n = timer;
    sel_n = sel;
    done_n = 1'b0;
    adv = 1'b0;
    jmp = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = DECODE;
        pc_n = ADDR_WIDTH'(START_PC);
      end
      DECODE: case (op)
        OP_HALT: begin
          state_n = IDLE;
          done_n = 1'b1;
        end
        OP_WAIT, OP_FILL, OP_REL, OP_FWD, OP_REV: if (imm == 16'd0) adv = 1'b1;
        else begin
          state_n = RUN;
          timer_n = imm;
          sel_n = {op == OP_REV, op == OP_FWD, op == OP_REL, op == OP_FILL};
        end
        OP_SET: begin
          lc_n = CNT_WIDTH'(imm);
          adv = 1'b1;
        end
        OP_DEC: begin
          lc_n = (loop_cnt == '0) ? '0 : loop_cnt - CNT_WIDTH'(1);
          adv = 1'b1;
        end
        OP_JZ, OP_JNZ: begin
          jmp = (loop_cnt == '0) == (op == OP_JZ);
          adv = !jmp;
        end
        default: state_n = FAULT;
      endcase
      RUN: if (tick && !paused) begin
        timer_n = timer - 16'd1;
        adv = timer == 16'd1;
      end
      default: ;
    endcase
    if (jmp) begin
      state_n = tgt_bad ? FAULT : DECODE;
      pc_n = tgt_bad ? pc : ADDR_WIDTH'(imm);
    end
    if (adv) begin
      state_n = inc_bad ? FAULT : DECODE;
      pc_n = inc_bad ? pc : pc_inc[ADDR_WIDTH-1:0];
    end
    act_n = (state_n == RUN && !(paused && state == RUN)) ? sel_n : 4'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      loop_cnt <= '0;
      timer <= '0;
      sel <= '0;
      {motor_rev, motor_fwd, drain_valve, fill_valve} <= 4'b0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      loop_cnt <= lc_n;
      timer <= timer_n;
      sel <= sel_n;
      {motor_rev, motor_fwd, drain_valve, fill_valve} <= act_n;
      busy <= (state_n == DECODE) || (state_n == RUN);
      done <= done_n;
      fault <= state_n == FAULT;
    end
  end
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: table vectors, hand sequences and random programs checked against an instruction-level model.
module tb_wash_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tick = 1'b0;
`ifdef WASH_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [31:0] instr;
  logic [7:0] pc;
  logic [15:0] loop_cnt;
  logic fill_valve, drain_valve, motor_fwd, motor_rev, busy, done, fault;
  logic [31:0] rom [256];
  assign instr = rom[pc];

  wash_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
`ifdef WASH_PAUSE_EN
    .pause(pause),
`endif
    .instr(instr), .pc(pc), .fill_valve(fill_valve), .drain_valve(drain_valve),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev), .busy(busy), .done(done),
    .fault(fault), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int tick_mode = 0, tcnt = 0;

  always @(posedge clk) begin
    #1;
    tcnt++;
    tick = (tick_mode == 1) ? (tcnt % 4 == 0) : (tick_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // pulse monitor: actuator index (0 fill, 1 drain, 2 fwd, 3 rev) and ticks seen while high
  int p_act[$], p_len[$];
  int done_cnt = 0, multi = 0;
  logic [3:0] prev = 4'b0;
  wire [3:0] acts = {motor_rev, motor_fwd, drain_valve, fill_valve};
  always @(negedge clk) begin
    if ($countones(acts) > 1) multi++;
    for (int a = 0; a < 4; a++) if (acts[a]) begin
      if (!prev[a]) begin p_act.push_back(a); p_len.push_back(0); end
      if (tick) begin
        int li;
        li = p_len.size() - 1;
        p_len[li] = p_len[li] + 1;
      end
    end
    if (done) done_cnt++;
    prev = acts;
  end

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  task automatic clear_rom();
    foreach (rom[k]) rom[k] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p_act.delete(); p_len.delete();
    done_cnt = 0; multi = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_prog(input string n, input int budget);
    int c;
    do_reset();
    pulse_start();
    @(negedge clk);
    c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    chk({n, "_busy_end"}, busy, 0);
    @(negedge clk);
  endtask

  // instruction-level reference: interprets the ROM directly
  int m_act[$], m_len[$];
  int m_lc, m_pc, m_fault;
  task automatic model();
    int p, lc, op, imm, nxt;
    logic [31:0] w;
    p = 2; lc = 0; m_fault = 0;
    m_act.delete(); m_len.delete();
    for (int s = 0; s < 2000; s++) begin
      w = rom[p];
      op = int'(w[7:0]);
      imm = int'(w[31:16]);
      if (op == 0) break;
      if (op >= 1 && op <= 5) begin
        if (imm > 0 && op >= 2) begin m_act.push_back(op - 2); m_len.push_back(imm); end
        nxt = p + 1;
      end else if (op == 'h11) begin lc = imm; nxt = p + 1; end
      else if (op == 'h12) begin lc = (lc > 0) ? lc - 1 : 0; nxt = p + 1; end
      else if (op == 'h21 || op == 'h22) nxt = ((lc == 0) == (op == 'h21)) ? imm : p + 1;
      else begin m_fault = 1; break; end
      if (nxt >= 64) begin m_fault = 1; break; end
      p = nxt;
    end
    m_pc = p; m_lc = lc;
  endtask

  task automatic compare_model(input string n);
    int k;
    model();
    chk({n, "_npulse"}, p_act.size(), m_act.size());
    k = (p_act.size() < m_act.size()) ? p_act.size() : m_act.size();
    for (int i = 0; i < k; i++) begin
      chk($sformatf("%s_act%0d", n, i), p_act[i], m_act[i]);
      chk($sformatf("%s_len%0d", n, i), p_len[i], m_len[i]);
    end
    chk({n, "_lc"}, loop_cnt, m_lc);
    chk({n, "_pc"}, pc, m_pc);
    chk({n, "_fault"}, fault, m_fault);
    chk({n, "_done"}, done_cnt, m_fault ? 0 : 1);
    chk({n, "_onehot"}, multi, 0);
  endtask

  logic [7:0] ill_tab [6] = '{8'h06, 8'h10, 8'h13, 8'h20, 8'h23, 8'hFF};
  task automatic gen_prog();
    int n, a, r, tgt;
    logic [31:0] w;
    clear_rom();
    n = $urandom_range(3, 12);
    for (int k = 0; k < n; k++) begin
      a = 2 + k;
      r = $urandom_range(0, 19);
      if (r < 8) w = {16'($urandom_range(0, 3)), 8'h0, 8'($urandom_range(1, 5))};
      else if (r < 10) w = {16'($urandom_range(0, 3)), 8'h0, 8'h11};
      else if (r < 13) w = {16'h0, 8'h0, 8'h12};
      else if (r < 17) begin
        tgt = (r == 16) ? $urandom_range(64, 70) : $urandom_range(a + 1, 2 + n);
        w = {16'(tgt), 8'h0, (r % 2 == 1) ? 8'h21 : 8'h22};
      end else if (r < 19) w = {16'($urandom_range(0, 3)) | 16'h0100, 8'h0, 8'h22};
      else w = {16'h0, 8'h0, ill_tab[$urandom_range(0, 5)]};
      w[15:8] = 8'($urandom);
      rom[a] = w;
    end
    rom[2 + n] = {16'($urandom), 8'($urandom), 8'h00};
  endtask

  typedef struct {
    logic [31:0] i0, i1;
    int lc, pc, flt, dn, np;
  } vec_t;
  vec_t tv[14];

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, c, fw;
    tv[0]  = '{32'h0005_0011, 32'h0000_0000, 5, 3, 0, 1, 0};
    tv[1]  = '{32'h0005_0011, 32'h0000_0012, 4, 4, 0, 1, 0};
    tv[2]  = '{32'h0000_0012, 32'h000A_0021, 0, 10, 0, 1, 0};
    tv[3]  = '{32'h0001_0011, 32'h000A_0021, 1, 4, 0, 1, 0};
    tv[4]  = '{32'h0001_0011, 32'h0014_0022, 1, 20, 0, 1, 0};
    tv[5]  = '{32'h0000_0007, 32'h0000_0000, 0, 2, 1, 0, 0};
    tv[6]  = '{32'h0001_0011, 32'h0040_0022, 1, 3, 1, 0, 0};
    tv[7]  = '{32'h0001_0011, 32'h0102_0022, 1, 3, 1, 0, 0};
    tv[8]  = '{32'h0000_0002, 32'h0000_0000, 0, 3, 0, 1, 0};
    tv[9]  = '{32'hFFFF_0011, 32'h0000_0000, 16'hFFFF, 3, 0, 1, 0};
    tv[10] = '{32'h0003_AB11, 32'h0000_CD12, 2, 4, 0, 1, 0};
    tv[11] = '{32'h0000_0013, 32'h0000_0000, 0, 2, 1, 0, 0};
    tv[12] = '{32'h0000_0001, 32'h000A_0022, 0, 4, 0, 1, 0};
    tv[13] = '{32'h0003_0004, 32'h0000_0000, 0, 3, 0, 1, 1};
    clear_rom();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_lc", loop_cnt, 0);
    chk("rst_acts", acts, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);

    tick_mode = 2;
    for (int i = 0; i < 14; i++) begin
      clear_rom();
      rom[2] = tv[i].i0;
      rom[3] = tv[i].i1;
      run_prog($sformatf("tv%0d", i), 500);
      chk($sformatf("tv%0d_lc", i), loop_cnt, tv[i].lc);
      chk($sformatf("tv%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("tv%0d_fault", i), fault, tv[i].flt);
      chk($sformatf("tv%0d_done", i), done_cnt, tv[i].dn);
      chk($sformatf("tv%0d_np", i), p_act.size(), tv[i].np);
    end

    // full wash program, tick every 4 cycles
    clear_rom();
    rom[2] = 32'h0064_0002; rom[3] = 32'h0032_0001; rom[4] = 32'h0005_0011;
    rom[5] = 32'h0014_0004; rom[6] = 32'h000A_0001; rom[7] = 32'h0014_0005;
    rom[8] = 32'h000A_0001; rom[9] = 32'h0000_0012; rom[10] = 32'h0005_0022;
    rom[11] = 32'h0064_0003; rom[12] = 32'h0000_0000;
    tick_mode = 1;
    run_prog("wash", 5000);
    chk("wash_npulse", p_act.size(), 12);
    chk("wash_fill_act", p_act.size() > 0 ? p_act[0] : -1, 0);
    chk("wash_fill_len", p_len.size() > 0 ? p_len[0] : -1, 100);
    fw = 0;
    foreach (p_act[i]) if (p_act[i] == 2 && p_len[i] == 20) fw++;
    chk("wash_fwd20", fw, 5);
    chk("wash_drain_act", p_act.size() > 0 ? p_act[p_act.size() - 1] : -1, 1);
    chk("wash_drain_len", p_len.size() > 0 ? p_len[p_len.size() - 1] : -1, 100);
    chk("wash_lc", loop_cnt, 0);
    chk("wash_done", done_cnt, 1);
    chk("wash_fault", fault, 0);
    compare_model("wash");

    // illegal opcode at pc 3; start ignored until reset
    clear_rom();
    rom[2] = 32'h0001_0011; rom[3] = 32'h0000_0007;
    run_prog("ill", 100);
    chk("ill_fault", fault, 1);
    chk("ill_acts", acts, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("ill_start_fault", fault, 1);
    chk("ill_start_busy", busy, 0);
    chk("ill_start_pc", pc, 3);
    do_reset();
    @(negedge clk);
    chk("ill_rst_fault", fault, 0);

    // zero-duration fill
    clear_rom();
    rom[2] = 32'h0000_0002;
    tick_mode = 2;
    do_reset();
    pulse_start();
    @(negedge clk);
    chk("zf_pc_dec", pc, 2);
    chk("zf_busy", busy, 1);
    @(negedge clk);
    chk("zf_pc_adv", pc, 3);
    chk("zf_fill", fill_valve, 0);
    @(negedge clk);
    chk("zf_done", done, 1);
    chk("zf_busy_end", busy, 0);

    // reset mid forward with 7 ticks remaining
    clear_rom();
    rom[2] = 32'h0014_0004;
    tick_mode = 1;
    do_reset();
    pulse_start();
    @(negedge clk);
    chk("rf_pc", pc, 2);
    chk("rf_decode_low", motor_fwd, 0);
    @(negedge clk);
    chk("rf_rise", motor_fwd, 1);
    n = 0; c = 0;
    while (c < 500) begin
      if (motor_fwd && tick) n++;
      if (n == 13) break;
      @(negedge clk);
      c++;
    end
    chk("rf_ticks", n, 13);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rf_timer7_high", motor_fwd, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rf_rst_fwd", motor_fwd, 0);
    chk("rf_rst_pc", pc, 0);
    chk("rf_rst_busy", busy, 0);
    pulse_start();
    @(negedge clk);
    chk("rf_restart_pc", pc, 2);

    // non-halt instruction at pc 63
    clear_rom();
    rom[2] = 32'h003F_0021; rom[63] = 32'h0002_0011;
    run_prog("p63", 100);
    chk("p63_fault", fault, 1);
    chk("p63_pc", pc, 63);

`ifdef WASH_PAUSE_EN
    clear_rom();
    rom[2] = 32'h0064_0002;
    tick_mode = 1;
    do_reset();
    pulse_start();
    n = 0; c = 0;
    while (n < 20 && c < 2000) begin @(negedge clk); c++; if (fill_valve && tick) n++; end
    @(posedge clk); #1;
    pause = 1'b1;
    n = 0; fw = 1;
    while (n < 30 && c < 4000) begin
      @(negedge clk); c++;
      if (tick) n++;
      if (n == 10 && tick) fw = fill_valve;
    end
    chk("pause_low", fw, 0);
    @(posedge clk); #1;
    pause = 1'b0;
    while (busy && c < 4000) begin @(negedge clk); c++; end
    @(negedge clk);
    fw = 0;
    foreach (p_act[i]) if (p_act[i] == 0) fw += p_len[i];
    chk("pause_total", fw, 100);
    chk("pause_split", p_act.size(), 2);
    chk("pause_done", done_cnt, 1);
`endif

    // random programs against the model
    tick_mode = 2;
    for (int r = 0; r < 40; r++) begin
      gen_prog();
      run_prog($sformatf("rnd%0d", r), 2000);
      compare_model($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
